// File: rtl/cphy_pkg.sv
// Shared types and constants for the C-PHY TX HS framing sequencer.
package cphy_pkg;

    typedef enum logic [2:0] {IDLE, PREAMBLE, PRE_HOLD, SYNC, DATA, POST} seq_state_e;

    // Sub-phases of the preamble when the programmable sequence is built in.
    typedef enum logic [1:0] {PH_LEAD, PH_PROG, PH_END} pre_phase_e;

    localparam logic [2:0]  SYM_PRE     = 3'd3;
    localparam logic [2:0]  SYM_POST    = 3'd4;
    localparam logic [20:0] SYNC_WORD   = {3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd3};
    localparam int          PROGSEQ_LEN = 14;
    localparam int          PREEND_LEN  = 7;

    // Sync word symbol for counter value idx (6 = first symbol sent, 0 = last).
    function automatic logic [2:0] sync_sym(input logic [2:0] idx);
        return SYNC_WORD[{2'b00, idx} * 5'd3 +: 3];
    endfunction

endpackage

// File: rtl/cphy_seq_cnt.sv
// Loadable down-counter with zero flag, shared by every run length of the sequencer.
module cphy_seq_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count_nxt,
    output logic         zero
);

    logic [W-1:0] count;

    // Saturates at zero so a stalled run never wraps around.
    always_comb begin
        count_nxt = count;
        if (load) begin
            count_nxt = load_val;
        end else if (dec && (count != '0)) begin
            count_nxt = count - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cphy_tx_hs_sequencer.sv
// C-PHY HS burst framing generator: preamble, sync word and post symbols toward the serializer.
// Optional build macro CPHY_TX_PROGSEQ_EN adds a programmable 14-symbol sequence inside the preamble.
module cphy_tx_hs_sequencer
    import cphy_pkg::*;
#(
    parameter int PREAMBLE_LEN = 21,
    parameter int POST_LEN     = 7,
    parameter int SYM_W        = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Sequencer_En,
    input  logic             Sync,
    input  logic             Post,
`ifdef CPHY_TX_PROGSEQ_EN
    input  logic [PROGSEQ_LEN*SYM_W-1:0] ProgSeq,
`endif
    output logic [SYM_W-1:0] Seq_Symbol,
    output logic             Seq_Valid,
    output logic             Pre_Done,
    output logic             Sync_Done,
    output logic             Post_Done
);

`ifdef CPHY_TX_PROGSEQ_EN
    localparam int RUN_MAX = (PREAMBLE_LEN > PROGSEQ_LEN) ? PREAMBLE_LEN : PROGSEQ_LEN;
`else
    localparam int RUN_MAX = PREAMBLE_LEN;
`endif
    localparam int CNT_MAX = (RUN_MAX > POST_LEN) ? RUN_MAX : POST_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX);

    seq_state_e       state, state_nxt;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val, cnt_nxt;
    logic [SYM_W-1:0] sym_d;
    logic             valid_d, pre_d, sync_d, post_d;

`ifdef CPHY_TX_PROGSEQ_EN
    pre_phase_e                   phase, phase_nxt;
    logic                         prog_cap;
    logic [PROGSEQ_LEN*SYM_W-1:0] prog_q;
    logic [3:0]                   prog_k;
`endif

    cphy_seq_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count_nxt(cnt_nxt),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
`ifdef CPHY_TX_PROGSEQ_EN
        phase_nxt    = phase;
        prog_cap     = 1'b0;
`endif
        if (!Sequencer_En) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt    = PREAMBLE;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(PREAMBLE_LEN - 1);
`ifdef CPHY_TX_PROGSEQ_EN
                    phase_nxt    = PH_LEAD;
                    prog_cap     = 1'b1;
`endif
                end
                PREAMBLE: begin
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else begin
`ifdef CPHY_TX_PROGSEQ_EN
                        case (phase)
                            PH_LEAD: begin
                                phase_nxt    = PH_PROG;
                                cnt_load     = 1'b1;
                                cnt_load_val = CNT_W'(PROGSEQ_LEN - 1);
                            end
                            PH_PROG: begin
                                phase_nxt    = PH_END;
                                cnt_load     = 1'b1;
                                cnt_load_val = CNT_W'(PREEND_LEN - 1);
                            end
                            default: state_nxt = PRE_HOLD;
                        endcase
`else
                        state_nxt = PRE_HOLD;
`endif
                    end
                end
                PRE_HOLD: begin
                    if (Sync) begin
                        state_nxt    = SYNC;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(6);
                    end
                end
                SYNC: begin
                    if (cnt_zero) state_nxt = DATA;
                    else          cnt_dec   = 1'b1;
                end
                DATA: begin
                    // Sync outranks Post; a Post seen together with Sync is dropped.
                    if (Sync) begin
                        state_nxt    = SYNC;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(6);
                    end else if (Post) begin
                        state_nxt    = POST;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(POST_LEN - 1);
                    end
                end
                POST: begin
                    if (cnt_zero) state_nxt = IDLE;
                    else          cnt_dec   = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state/count so the registered values line up with it.
    always_comb begin
        sym_d   = '0;
        valid_d = 1'b0;
        pre_d   = 1'b0;
        sync_d  = 1'b0;
        post_d  = 1'b0;
`ifdef CPHY_TX_PROGSEQ_EN
        prog_k  = '0;
`endif
        case (state_nxt)
            PREAMBLE: begin
                valid_d = 1'b1;
                sym_d   = SYM_W'(SYM_PRE);
`ifdef CPHY_TX_PROGSEQ_EN
                if (phase_nxt == PH_PROG) begin
                    prog_k = 4'(PROGSEQ_LEN - 1) - cnt_nxt[3:0];
                    sym_d  = prog_q[{2'b00, prog_k} * 6'(SYM_W) +: SYM_W];
                end
                pre_d = (phase_nxt == PH_END) && (cnt_nxt == '0);
`else
                pre_d = (cnt_nxt == '0);
`endif
            end
            PRE_HOLD: begin
                valid_d = 1'b1;
                sym_d   = SYM_W'(SYM_PRE);
            end
            SYNC: begin
                valid_d = 1'b1;
                sym_d   = SYM_W'(sync_sym(cnt_nxt[2:0]));
                sync_d  = (cnt_nxt == '0);
            end
            POST: begin
                valid_d = 1'b1;
                sym_d   = SYM_W'(SYM_POST);
                post_d  = (cnt_nxt == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            Seq_Symbol <= '0;
            Seq_Valid  <= 1'b0;
            Pre_Done   <= 1'b0;
            Sync_Done  <= 1'b0;
            Post_Done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            Seq_Symbol <= sym_d;
            Seq_Valid  <= valid_d;
            Pre_Done   <= pre_d;
            Sync_Done  <= sync_d;
            Post_Done  <= post_d;
        end
    end

`ifdef CPHY_TX_PROGSEQ_EN
    // The sequence is frozen at burst start; later ProgSeq changes wait for the next burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase  <= PH_LEAD;
            prog_q <= '0;
        end else begin
            phase <= phase_nxt;
            if (prog_cap) prog_q <= ProgSeq;
        end
    end
`endif

endmodule
